// File: rtl/stack_port_arbiter.sv
// Two-port round-robin arbiter in front of a single stack/queue memory.
// Each port runs a 4-phase req/ack handshake; accepted ops emit exactly one push/pop strobe.
module stack_port_arbiter #(
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0,
    input  logic          i_op0,
    input  logic [DW-1:0] i_wdata0,
    output logic          o_ack0,
    output logic          o_err0,
    output logic [DW-1:0] o_rdata0,
    input  logic          i_req1,
    input  logic          i_op1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_ack1,
    output logic          o_err1,
    output logic [DW-1:0] o_rdata1,
    output logic          o_mem_push,
    output logic          o_mem_pop,
    output logic [DW-1:0] o_mem_din,
    input  logic [DW-1:0] i_mem_dout,
    input  logic          i_mem_empty,
    input  logic          i_mem_full,
    output logic          o_busy,
    output logic          o_grant
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        r_state, w_next;
    logic          r_grant, r_op, r_err;
    logic [DW-1:0] r_wdata, r_rdata0, r_rdata1;
    logic [2:0]    r_cnt;
    logic          w_win, w_op, w_reject, w_take, w_wait_end, w_req_own;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Tie goes to the port that did not win last; a lone request wins outright.
    always_comb begin
        w_win      = (i_req0 && i_req1) ? ~r_grant : i_req1;
        w_op       = w_win ? i_op1 : i_op0;
        w_reject   = w_op ? i_mem_empty : i_mem_full;
        w_take     = (r_state == S_IDLE) && (i_req0 || i_req1);
        w_wait_end = (r_state == S_WAIT) && (r_cnt == 3'(MEM_LAT - 1));
        w_req_own  = r_grant ? i_req1 : i_req0;
        w_next     = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_next = w_reject ? S_DONE : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_wait_end) w_next = S_DONE;
            S_DONE:  if (!w_req_own) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_push = 1'b0;
        o_mem_pop  = 1'b0;
        o_mem_din  = '0;
        if (r_state == S_ISSUE) begin
            o_mem_push = ~r_op;
            o_mem_pop  = r_op;
            o_mem_din  = r_wdata;
        end
        o_ack0 = (r_state == S_DONE) && !r_grant;
        o_ack1 = (r_state == S_DONE) && r_grant;
        o_err0 = o_ack0 && r_err;
        o_err1 = o_ack1 && r_err;
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_grant  = r_grant;
    assign o_rdata0 = r_rdata0;
    assign o_rdata1 = r_rdata1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant  <= 1'b1;
            r_op     <= 1'b0;
            r_err    <= 1'b0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_take) begin
                r_grant <= w_win;
                r_op    <= w_op;
                r_wdata <= w_win ? i_wdata1 : i_wdata0;
                r_err   <= w_reject;
            end
            if (r_state == S_ISSUE)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 3'd1;
            // Memory data is valid on the edge that closes the last wait cycle.
            if (w_wait_end && r_op) begin
                if (r_grant) r_rdata1 <= i_mem_dout;
                else         r_rdata0 <= i_mem_dout;
            end
        end
    end
endmodule

// File: tb/tb_stack_port_arbiter.sv
// Bench for stack_port_arbiter: directed vector table, corner sequences, and a random
// two-port run checked against a transaction-level stack reference.
module tb_stack_port_arbiter;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 0, op0 = 0, req1 = 0, op1 = 0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic ack0, err0, ack1, err1, mem_push, mem_pop, busy, grant;
    logic [DW-1:0] rdata0, rdata1, mem_din, mem_dout;
    logic mem_empty, mem_full;

    logic use_model = 1'b0;
    logic [DW-1:0] d_dout = '0, m_dout = '0;
    logic d_empty = 1'b0, d_full = 1'b0;
    int m_cnt = 0;
    logic [DW-1:0] stk[$];

    int total = 0, bad = 0;
    int n_push = 0, n_pop = 0, n_both = 0, n_ackbad = 0;

    assign mem_dout  = use_model ? m_dout : d_dout;
    assign mem_empty = use_model ? (m_cnt == 0) : d_empty;
    assign mem_full  = use_model ? (m_cnt == DEPTH) : d_full;

    stack_port_arbiter #(.DW(DW), .MEM_LAT(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_op0(op0), .i_wdata0(wdata0), .o_ack0(ack0), .o_err0(err0), .o_rdata0(rdata0),
        .i_req1(req1), .i_op1(op1), .i_wdata1(wdata1), .o_ack1(ack1), .o_err1(err1), .o_rdata1(rdata1),
        .o_mem_push(mem_push), .o_mem_pop(mem_pop), .o_mem_din(mem_din), .i_mem_dout(mem_dout),
        .i_mem_empty(mem_empty), .i_mem_full(mem_full), .o_busy(busy), .o_grant(grant)
    );

    always #5 clk = ~clk;

    // Stack memory used in the random phase; popped word appears one cycle after the strobe.
    always @(posedge clk) begin
        if (rst) begin
            stk.delete();
            m_cnt <= 0;
        end else if (use_model) begin
            if (mem_push) stk.push_back(mem_din);
            if (mem_pop && stk.size() > 0) begin
                m_dout <= stk[$];
                stk.pop_back();
            end
            m_cnt <= stk.size();
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (mem_push) n_push <= n_push + 1;
            if (mem_pop) n_pop <= n_pop + 1;
            if (mem_push && mem_pop) n_both <= n_both + 1;
            if ((ack0 && grant) || (ack1 && !grant)) n_ackbad <= n_ackbad + 1;
        end
    end

    typedef struct {
        bit port; bit op; logic [DW-1:0] wdata; bit full; bit empty; logic [DW-1:0] dout;
        bit err; int ack_cyc; int npush; int npop; logic [DW-1:0] r0; logic [DW-1:0] r1;
    } vec_t;
    vec_t vt[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        req0 = 0; req1 = 0; rst = 1;
        tick; tick;
        rst = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int c, ac, np, npo, ns;
        logic [DW-1:0] din;
        d_full = v.full; d_empty = v.empty; d_dout = v.dout;
        if (v.port) begin req1 = 1; op1 = v.op; wdata1 = v.wdata; end
        else        begin req0 = 1; op0 = v.op; wdata0 = v.wdata; end
        c = 0; ac = -1; np = 0; npo = 0; ns = 0; din = '0;
        while (ac < 0 && c < 12) begin
            tick; c++;
            if (mem_push) begin np++; din = mem_din; end
            if (mem_pop) npo++;
            if (v.port ? ack1 : ack0) ac = c;
        end
        chk("ack_cycle", ac, v.ack_cyc);
        chk1("err", v.port ? err1 : err0, v.err);
        chk("push_strobes", np, v.npush);
        chk("pop_strobes", npo, v.npop);
        if (v.npush > 0) chk("mem_din", din, v.wdata);
        chk("rdata0", rdata0, v.r0);
        chk("rdata1", rdata1, v.r1);
        chk1("other_ack", v.port ? ack0 : ack1, 1'b0);
        repeat (2) begin
            tick;
            if (mem_push || mem_pop) ns++;
        end
        chk1("ack_held", v.port ? ack1 : ack0, 1'b1);
        chk("hold_strobes", ns, 0);
        if (v.port) req1 = 0; else req0 = 0;
        tick;
        chk1("ack_release", v.port ? ack1 : ack0, 1'b0);
        chk1("busy_release", busy, 1'b0);
    endtask

    task automatic run_pair(input int first);
        int order[$];
        int s;
        s = n_push;
        d_full = 0; d_empty = 0;
        req0 = 1; op0 = 0; wdata0 = $urandom;
        req1 = 1; op1 = 0; wdata1 = $urandom;
        for (int c = 0; c < 40 && (req0 || req1); c++) begin
            tick;
            if (req0 && ack0) begin order.push_back(0); req0 = 0; end
            if (req1 && ack1) begin order.push_back(1); req1 = 0; end
        end
        chk1("pair_timeout", req0 | req1, 1'b0);
        tick;
        chk("pair_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("pair_first", order[0], first);
            chk("pair_second", order[1], 1 - first);
        end
        chk("pair_pushes", n_push - s, 2);
    endtask

    task automatic rnd_phase;
        logic [DW-1:0] refq[$];
        logic [DW-1:0] rwd[2];
        logic [DW-1:0] exp_rd;
        bit pend[2], rop[2];
        bit exp_err, a;
        int rise[2];
        int last_p, last_ack, base, accepted, max_wait;
        last_p = -1; last_ack = 0; accepted = 0; max_wait = 0;
        pend[0] = 0; pend[1] = 0; rise[0] = 0; rise[1] = 0;
        base = n_push + n_pop;
        for (int t = 0; t < 2400; t++) begin
            tick;
            if (t >= 2000 && !pend[0] && !pend[1]) break;
            for (int p = 0; p < 2; p++) begin
                a = (p == 1) ? ack1 : ack0;
                if (pend[p] && a) begin
                    exp_rd = '0;
                    if (!rop[p]) begin
                        exp_err = (refq.size() == DEPTH);
                        if (!exp_err) begin refq.push_back(rwd[p]); accepted++; end
                    end else begin
                        exp_err = (refq.size() == 0);
                        if (!exp_err) begin exp_rd = refq[$]; refq.pop_back(); accepted++; end
                    end
                    chk1("rnd_err", (p == 1) ? err1 : err0, exp_err);
                    if (rop[p] && !exp_err) chk("rnd_rdata", (p == 1) ? rdata1 : rdata0, exp_rd);
                    chk1("rnd_fairness", (last_p == p) && pend[1-p] && (rise[1-p] <= last_ack), 1'b0);
                    last_p = p; last_ack = t; pend[p] = 0;
                end else if (pend[p]) begin
                    if (t - rise[p] > max_wait) max_wait = t - rise[p];
                end else if (t < 2000 && $urandom_range(2) == 0) begin
                    pend[p] = 1; rop[p] = 1'($urandom_range(1)); rwd[p] = $urandom; rise[p] = t;
                end
            end
            req0 = pend[0]; op0 = rop[0]; wdata0 = rwd[0];
            req1 = pend[1]; op1 = rop[1]; wdata1 = rwd[1];
        end
        tick; tick;
        chk1("rnd_drained", pend[0] | pend[1], 1'b0);
        chk1("rnd_max_wait", max_wait > 60, 1'b0);
        chk("rnd_strobes", n_push + n_pop - base, accepted);
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,     1'b0, 3, 1, 0, 32'h0,     32'h0};
        vt[1] = '{1'b1, 1'b1, 32'h0,       1'b0, 1'b0, 32'h1234,  1'b0, 3, 0, 1, 32'h0,     32'h1234};
        vt[2] = '{1'b1, 1'b1, 32'h0,       1'b0, 1'b1, 32'h9999,  1'b1, 1, 0, 0, 32'h0,     32'h1234};
        vt[3] = '{1'b0, 1'b0, 32'h7777,    1'b1, 1'b0, 32'h0,     1'b1, 1, 0, 0, 32'h0,     32'h1234};
        vt[4] = '{1'b0, 1'b1, 32'h0,       1'b0, 1'b0, 32'hCAFE,  1'b0, 3, 0, 1, 32'hCAFE,  32'h1234};
        vt[5] = '{1'b1, 1'b0, 32'hA5A5A5A5,1'b0, 1'b1, 32'h0,     1'b0, 3, 1, 0, 32'hCAFE,  32'h1234};
        vt[6] = '{1'b0, 1'b1, 32'h0,       1'b1, 1'b0, 32'h55AA,  1'b0, 3, 0, 1, 32'h55AA,  32'h1234};

        do_reset;
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_ack1", ack1, 1'b0);
        chk1("rst_err0", err0, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_push", mem_push, 1'b0);
        chk1("rst_pop", mem_pop, 1'b0);
        chk1("rst_grant", grant, 1'b1);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_din", mem_din, 32'h0);

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Port 0 keeps req0 up after ack while port 1 waits.
        d_full = 0; d_empty = 0;
        req0 = 1; op0 = 0; wdata0 = 32'h1111;
        tick;
        req1 = 1; op1 = 0; wdata1 = 32'h2222;
        for (int c = 0; c < 10 && !ack0; c++) tick;
        chk1("hold_ack0_seen", ack0, 1'b1);
        begin
            int s;
            s = n_push + n_pop;
            repeat (5) begin
                tick;
                chk1("hold_ack0", ack0, 1'b1);
                chk1("hold_ack1", ack1, 1'b0);
            end
            chk("hold_no_strobe", n_push + n_pop - s, 0);
        end
        req0 = 0;
        tick;
        chk1("hold_idle", busy, 1'b0);
        tick;
        chk1("hold_grant1", grant, 1'b1);
        chk1("hold_push1", mem_push, 1'b1);
        chk("hold_din1", mem_din, 32'h2222);
        tick; tick;
        chk1("hold_ack1_done", ack1, 1'b1);
        req1 = 0;
        tick;

        // Reset during WAIT aborts the pop; the held request is served again.
        d_dout = 32'h0BADF00D;
        req0 = 1; op0 = 1;
        tick;
        chk1("rw_pop_first", mem_pop, 1'b1);
        tick;
        chk1("rw_busy_wait", busy, 1'b1);
        rst = 1;
        tick;
        rst = 0;
        chk1("rw_busy", busy, 1'b0);
        chk1("rw_ack0", ack0, 1'b0);
        chk1("rw_no_pop", mem_pop, 1'b0);
        chk("rw_rdata0", rdata0, 32'h0);
        tick;
        chk1("rw_pop_again", mem_pop, 1'b1);
        tick; tick;
        chk1("rw_ack0_done", ack0, 1'b1);
        chk("rw_rdata0_done", rdata0, 32'h0BADF00D);
        req0 = 0;
        tick;

        do_reset;
        run_pair(0);
        run_vec('{1'b0, 1'b0, 32'h3, 1'b0, 1'b0, 32'h0, 1'b0, 3, 1, 0, 32'h0, 32'h0});
        run_pair(1);

        use_model = 1;
        do_reset;
        rnd_phase;

        chk("never_both_strobes", n_both, 0);
        chk("ack_only_granted", n_ackbad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
